ts_ser2par: RTL and testbench
=============================

TS_SER2PAR -- requirements
Module: ts_ser2par

Interface
REQ-001 Parameter U_DLY, default 1, register-assignment delay used in simulation only.
REQ-002 Parameter PID_CHECK, default 13'h0014, the PID whose continuity counter is checked.
REQ-003 Parameter PKT_LEN, default 188, packet length in bytes.
REQ-004 Port clk, input, 1 bit, sole clock; every serial input is sampled on its rising edge.
REQ-005 Port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 Port ts_valid_ser, input, 1 bit, marks ts_data_ser as a valid bit this cycle.
REQ-007 Port ts_data_ser, input, 1 bit, serial TS data, LSB of each byte first.
REQ-008 Port ts_sync_ser, input, 1 bit, packet start; high together with the first valid bit of byte 0x47.
REQ-009 Port ts_valid, output, 1 bit, one-cycle strobe qualifying ts_data.
REQ-010 Port ts_data, output, 8 bits, assembled parallel byte.
REQ-011 Port ts_sync, output, 1 bit, high with ts_valid for byte 0 of a packet.
REQ-012 Port ts_eop, output, 1 bit, high with ts_valid for byte PKT_LEN-1.
REQ-013 Port sync_err, output, 1 bit, one-cycle pulse on a framing error.
REQ-014 Port cc_err, output, 1 bit, one-cycle pulse on a continuity-counter discontinuity.
REQ-015 Port pkt_cnt, output, 16 bits, number of complete packets received, saturating.
REQ-016 Port err_cnt, output, 16 bits, number of sync_err plus cc_err events, saturating.

Function
REQ-017 The block SHALL implement a two-state FSM: HUNT and RECV.
REQ-018 HUNT SHALL ignore every bit until ts_sync_ser=1 and ts_valid_ser=1; that bit SHALL be bit 0 of byte 0, and the FSM SHALL move to RECV.
REQ-019 In RECV, each cycle with ts_valid_ser=1 SHALL shift one bit into bit position bit_cnt; cycles with ts_valid_ser=0 SHALL hold all state, so gaps of any length are allowed.
REQ-020 When the 8th bit of a byte is sampled, the byte SHALL appear on ts_data with ts_valid=1 on the next cycle (latency 1 clk); ts_data SHALL hold its value between strobes.
REQ-021 Byte 0 SHALL be compared with 8'h47.
  - Match: output it with ts_sync=1.
  - Mismatch: no ts_valid, sync_err=1, FSM returns to HUNT.
REQ-022 Byte index PKT_LEN-1 SHALL be output with ts_eop=1; the FSM SHALL return to HUNT in that same update.
REQ-023 A ts_sync_ser=1 with ts_valid_ser=1 in RECV at any position other than bit 0 of byte 0 SHALL:
  - pulse sync_err;
  - discard the partial byte;
  - restart the packet with that bit as bit 0 of byte 0;
  - not assert ts_eop for the truncated packet.
REQ-024 ts_sync_ser=1 in HUNT or RECV SHALL be ignored when ts_valid_ser=0.
REQ-025 PID SHALL be taken as {byte1[4:0], byte2}; CC as byte3[3:0]; AFC as byte3[5:4].
REQ-026 CC check SHALL apply only when PID==PID_CHECK.
  - Expected value is prev_cc+1 mod 16 when AFC[0]=1, otherwise prev_cc.
  - A mismatch SHALL pulse cc_err in the same cycle as the byte-3 ts_valid.
  - The received CC SHALL then become prev_cc in every case.
REQ-027 The first matching-PID packet after reset SHALL load prev_cc without a check; a cc_vld flag records this.
REQ-028 pkt_cnt SHALL increment on each ts_eop and saturate at 16'hFFFF.
REQ-029 err_cnt SHALL add sync_err+cc_err each cycle (+2 when both pulse in one cycle) and saturate at 16'hFFFF without wrapping.
REQ-030 Internal byte index SHALL be 8 bits wide and SHALL never exceed PKT_LEN-1.

Reset
REQ-031 While rst=1:
  - FSM=HUNT;
  - ts_valid, ts_sync, ts_eop, sync_err, cc_err = 0;
  - ts_data = 8'h00;
  - pkt_cnt, err_cnt = 16'h0000;
  - cc_vld = 0, prev_cc = 4'h0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet; after release the block SHALL hunt afresh and emit nothing until a new ts_sync_ser.

Verification
REQ-033 Stream of 8-bit-valid / 8-bit-gap packets (0x47, 0x00, 0x14, 0x1n, 4, 5, ... 187) with CC 0..3 -> 188 strobes per packet, ts_sync on 0x47, ts_eop on byte 187, pkt_cnt=4, err_cnt=0, cc_err never.
REQ-034 CC sequence 0,1,3 on PID 0x0014 -> a single cc_err on packet 3 byte 3, err_cnt=1; the same CC sequence on PID 0x0015 -> no cc_err.
REQ-035 ts_sync_ser with first byte 0xB8 -> sync_err pulse, no ts_valid, FSM back to HUNT; the next good packet is received intact.
REQ-036 Second ts_sync_ser at byte 100 bit 3 -> sync_err, no ts_eop for the first packet, new packet of 188 bytes completes, pkt_cnt=1.
REQ-037 rst pulsed at byte 50 -> all outputs 0 within the reset, then a clean packet yields pkt_cnt=1.
REQ-038 Force err_cnt to 16'hFFFE, inject cc_err and sync_err in the same cycle -> err_cnt=16'hFFFF and holds.

Source files
------------

// File: rtl/ts_ser2par_if.sv
// Serial MPEG-TS input bundle and the parallel byte stream it is converted into.
// The slave modport is the converter's view; the master modport is the source/sink side.
interface ts_ser2par_if;
    logic       ts_valid_ser;
    logic       ts_data_ser;
    logic       ts_sync_ser;
    logic       ts_valid;
    logic [7:0] ts_data;
    logic       ts_sync;
    logic       ts_eop;

    modport master (
        output ts_valid_ser, ts_data_ser, ts_sync_ser,
        input  ts_valid, ts_data, ts_sync, ts_eop
    );

    modport slave (
        input  ts_valid_ser, ts_data_ser, ts_sync_ser,
        output ts_valid, ts_data, ts_sync, ts_eop
    );
endinterface

// File: rtl/ts_ser2par.sv
// Serial-to-parallel MPEG-TS converter: frames packets on the 0x47 sync byte,
// emits bytes one clock after their last bit, and checks the continuity counter of one PID.
module ts_ser2par #(
    parameter int unsigned U_DLY     = 1,
    parameter logic [12:0] PID_CHECK = 13'h0014,
    parameter int unsigned PKT_LEN   = 188
) (
    input  logic               clk,
    input  logic               rst,
    ts_ser2par_if.slave        ts,
    output logic               sync_err,
    output logic               cc_err,
    output logic [15:0]        pkt_cnt,
    output logic [15:0]        err_cnt
);

    localparam logic [7:0] LAST_IDX  = 8'(PKT_LEN - 1);
    localparam logic [7:0] SYNC_BYTE = 8'h47;

    // The register-assignment delay only matters to delay-annotated simulation
    // models; this implementation applies none.
    if (U_DLY > 32'd1000) begin : g_udly_unused
    end

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_idx;
    logic [6:0]  shreg;
    logic [4:0]  pid_hi;
    logic [7:0]  pid_lo;
    logic        cc_vld;
    logic [3:0]  prev_cc;

    logic        restart;
    logic        shift;
    logic        byte_done;
    logic [7:0]  byte_full;
    logic        pid_match;
    logic [1:0]  err_inc;

    function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, acc} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [3:0] cc_expect(input logic [3:0] prev, input logic afc0);
        return afc0 ? prev + 4'd1 : prev;
    endfunction

    // A valid bit with sync always starts a fresh packet; anything else only
    // advances the assembly while a packet is being received.
    assign restart   = ts.ts_valid_ser & ts.ts_sync_ser;
    assign shift     = ts.ts_valid_ser & ~ts.ts_sync_ser & (state == RECV);
    assign byte_done = shift & (bit_cnt == 3'd7);
    assign byte_full = {ts.ts_data_ser, shreg};
    assign pid_match = ({pid_hi, pid_lo} == PID_CHECK);
    assign err_inc   = {1'b0, sync_err} + {1'b0, cc_err};

    // Byte assembly and PID capture: pure data, no reset needed
    always_ff @(posedge clk) begin
        if (restart) begin
            shreg <= {6'd0, ts.ts_data_ser};
        end else if (shift && bit_cnt != 3'd7) begin
            shreg[bit_cnt] <= ts.ts_data_ser;
        end
        if (byte_done && byte_idx == 8'd1) begin
            pid_hi <= byte_full[4:0];
        end
        if (byte_done && byte_idx == 8'd2) begin
            pid_lo <= byte_full;
        end
    end

    // Framing FSM, registered outputs and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            bit_cnt    <= 3'd0;
            byte_idx   <= 8'd0;
            cc_vld     <= 1'b0;
            prev_cc    <= 4'h0;
            ts.ts_valid <= 1'b0;
            ts.ts_data  <= 8'h00;
            ts.ts_sync  <= 1'b0;
            ts.ts_eop   <= 1'b0;
            sync_err   <= 1'b0;
            cc_err     <= 1'b0;
            pkt_cnt    <= 16'h0000;
            err_cnt    <= 16'h0000;
        end else begin
            ts.ts_valid <= 1'b0;
            ts.ts_sync  <= 1'b0;
            ts.ts_eop   <= 1'b0;
            sync_err   <= 1'b0;
            cc_err     <= 1'b0;
            pkt_cnt    <= sat_add16(pkt_cnt, {1'b0, ts.ts_eop});
            err_cnt    <= sat_add16(err_cnt, err_inc);

            if (restart) begin
                // In RECV the current bit can never be bit 0 of byte 0, so a
                // sync here always truncates the packet in progress.
                if (state == RECV) begin
                    sync_err <= 1'b1;
                end
                state    <= RECV;
                bit_cnt  <= 3'd1;
                byte_idx <= 8'd0;
            end else if (shift) begin
                if (bit_cnt != 3'd7) begin
                    bit_cnt <= bit_cnt + 3'd1;
                end else begin
                    bit_cnt <= 3'd0;
                    if (byte_idx == 8'd0 && byte_full != SYNC_BYTE) begin
                        sync_err <= 1'b1;
                        state    <= HUNT;
                    end else begin
                        ts.ts_valid <= 1'b1;
                        ts.ts_data  <= byte_full;
                        ts.ts_sync  <= (byte_idx == 8'd0);
                        if (byte_idx == 8'd3 && pid_match) begin
                            if (cc_vld && byte_full[3:0] != cc_expect(prev_cc, byte_full[4])) begin
                                cc_err <= 1'b1;
                            end
                            prev_cc <= byte_full[3:0];
                            cc_vld  <= 1'b1;
                        end
                        if (byte_idx == LAST_IDX) begin
                            ts.ts_eop <= 1'b1;
                            state     <= HUNT;
                            byte_idx  <= 8'd0;
                        end else begin
                            byte_idx <= byte_idx + 8'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ts_ser2par.sv
// Directed bench for ts_ser2par: a bit-stream reference model is compared with the
// DUT every cycle, and per-scenario literal expectations pin the model.
module tb_ts_ser2par;

    localparam logic [12:0] PID_CHK = 13'h0014;
    localparam int          PKT_LEN = 188;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync_err;
    logic        cc_err;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;

    ts_ser2par_if ts_if ();

    ts_ser2par #(
        .U_DLY     (1),
        .PID_CHECK (PID_CHK),
        .PKT_LEN   (PKT_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ts       (ts_if),
        .sync_err (sync_err),
        .cc_err   (cc_err),
        .pkt_cnt  (pkt_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_active;
    int          m_nbits;
    logic [7:0]  m_cur;
    logic [7:0]  m_hdr [4];
    logic        m_have_cc;
    logic [3:0]  m_prev_cc;
    logic        exp_valid, exp_sync, exp_eop, exp_serr, exp_ccerr;
    logic [7:0]  exp_data;
    logic [15:0] exp_pkt, exp_err;
    logic        chk_en = 1'b1;

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    task automatic model_reset();
        m_active  = 1'b0;
        m_nbits   = 0;
        m_cur     = 8'h00;
        m_have_cc = 1'b0;
        m_prev_cc = 4'h0;
        exp_valid = 1'b0;
        exp_sync  = 1'b0;
        exp_eop   = 1'b0;
        exp_serr  = 1'b0;
        exp_ccerr = 1'b0;
        exp_data  = 8'h00;
        exp_pkt   = 16'h0000;
        exp_err   = 16'h0000;
    endtask

    // Predicts the outputs after the coming rising edge from the inputs it will sample.
    task automatic model_step();
        logic [7:0] bv;
        logic [3:0] want;
        int         idx;
        exp_pkt   = sat16(int'(exp_pkt) + int'(exp_eop));
        exp_err   = sat16(int'(exp_err) + int'(exp_serr) + int'(exp_ccerr));
        exp_valid = 1'b0;
        exp_sync  = 1'b0;
        exp_eop   = 1'b0;
        exp_serr  = 1'b0;
        exp_ccerr = 1'b0;
        if (ts_if.ts_valid_ser !== 1'b1) return;
        if (ts_if.ts_sync_ser === 1'b1) begin
            if (m_active) exp_serr = 1'b1;
            m_active = 1'b1;
            m_nbits  = 0;
            m_cur    = 8'h00;
        end
        if (!m_active) return;
        m_cur[m_nbits % 8] = ts_if.ts_data_ser;
        m_nbits++;
        if (m_nbits % 8 != 0) return;
        idx   = m_nbits / 8 - 1;
        bv    = m_cur;
        m_cur = 8'h00;
        if (idx == 0 && bv != 8'h47) begin
            exp_serr = 1'b1;
            m_active = 1'b0;
            return;
        end
        exp_valid = 1'b1;
        exp_data  = bv;
        exp_sync  = (idx == 0);
        if (idx < 4) m_hdr[idx] = bv;
        if (idx == 3 && {m_hdr[1][4:0], m_hdr[2]} == PID_CHK) begin
            want = bv[4] ? m_prev_cc + 4'd1 : m_prev_cc;
            if (m_have_cc && bv[3:0] != want) exp_ccerr = 1'b1;
            m_prev_cc = bv[3:0];
            m_have_cc = 1'b1;
        end
        if (idx == PKT_LEN - 1) begin
            exp_eop  = 1'b1;
            m_active = 1'b0;
        end
    endtask

    // ---------------- event counters and per-cycle compare ----------------
    int         n_valid = 0, n_eop = 0, n_serr = 0, n_ccerr = 0;
    logic [7:0] last_cc_data  = 8'h00;
    logic [7:0] last_eop_data = 8'h00;

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            if (ts_if.ts_valid === 1'b1) n_valid++;
            if (ts_if.ts_eop === 1'b1) begin
                n_eop++;
                last_eop_data = ts_if.ts_data;
            end
            if (sync_err === 1'b1) n_serr++;
            if (cc_err === 1'b1) begin
                n_ccerr++;
                last_cc_data = ts_if.ts_data;
            end
            if (chk_en) begin
                check("ts_valid", 16'(ts_if.ts_valid), 16'(exp_valid));
                check("ts_data",  16'(ts_if.ts_data),  16'(exp_data));
                check("ts_sync",  16'(ts_if.ts_sync),  16'(exp_sync));
                check("ts_eop",   16'(ts_if.ts_eop),   16'(exp_eop));
                check("sync_err", 16'(sync_err),       16'(exp_serr));
                check("cc_err",   16'(cc_err),         16'(exp_ccerr));
                check("pkt_cnt",  pkt_cnt,             exp_pkt);
                check("err_cnt",  err_cnt,             exp_err);
            end
            if (!rst) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sy);
        ts_if.ts_valid_ser = 1'b1;
        ts_if.ts_data_ser  = b;
        ts_if.ts_sync_ser  = sy;
        cyc();
        ts_if.ts_valid_ser = 1'b0;
        ts_if.ts_sync_ser  = 1'b0;
        ts_if.ts_data_ser  = 1'b0;
    endtask

    // Gap cycles carry junk data and stray sync levels that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            ts_if.ts_valid_ser = 1'b0;
            ts_if.ts_data_ser  = i[0];
            ts_if.ts_sync_ser  = (i % 3 == 0);
            cyc();
        end
        ts_if.ts_sync_ser = 1'b0;
        ts_if.ts_data_ser = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sy);
        for (int i = 0; i < 8; i++) send_bit(b[i], sy && i == 0);
    endtask

    function automatic logic [7:0] pkt_byte(input int k, input logic [12:0] pid, input logic [3:0] cc);
        if (k == 0) return 8'h47;
        if (k == 1) return {3'b000, pid[12:8]};
        if (k == 2) return pid[7:0];
        if (k == 3) return {4'h1, cc};
        return 8'(k);
    endfunction

    // Sends bit positions [start_bit, stop_bits) of a packet (stop_bits<0: to the end).
    task automatic send_pkt(input logic [12:0] pid, input logic [3:0] cc, input int gap_n,
                            input int start_bit, input int stop_bits);
        logic [7:0] b;
        for (int k = 0; k < PKT_LEN; k++) begin
            b = pkt_byte(k, pid, cc);
            for (int i = 0; i < 8; i++) begin
                int pos;
                pos = k * 8 + i;
                if (pos < start_bit) continue;
                if (stop_bits >= 0 && pos >= stop_bits) return;
                send_bit(b[i], pos == 0);
            end
            if (gap_n > 0 && k * 8 + 8 > start_bit) idle(gap_n);
        end
    endtask

    task automatic do_reset();
        ts_if.ts_valid_ser = 1'b0;
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        idle(2);
    endtask

    int b_valid, b_eop, b_serr, b_ccerr;

    task automatic snap();
        b_valid = n_valid;
        b_eop   = n_eop;
        b_serr  = n_serr;
        b_ccerr = n_ccerr;
    endtask

    initial begin
        ts_if.ts_valid_ser = 1'b0;
        ts_if.ts_data_ser  = 1'b0;
        ts_if.ts_sync_ser  = 1'b0;
        @(negedge clk);
        check("rst_ts_valid", 16'(ts_if.ts_valid), 16'h0000);
        check("rst_ts_data",  16'(ts_if.ts_data),  16'h0000);
        check("rst_pkt_cnt",  pkt_cnt, 16'h0000);
        check("rst_err_cnt",  err_cnt, 16'h0000);
        cyc();
        do_reset();

        // Four good packets, 8 valid bits then 8 idle cycles, CC 0..3
        snap();
        for (int p = 0; p < 4; p++) send_pkt(PID_CHK, 4'(p), 8, 0, -1);
        idle(10);
        check("t1_strobes", 16'(n_valid - b_valid), 16'd752);
        check("t1_eops",    16'(n_eop - b_eop),     16'd4);
        check("t1_ccerrs",  16'(n_ccerr - b_ccerr), 16'd0);
        check("t1_eop_data", 16'(last_eop_data),    16'h00BB);
        check("t1_pkt_cnt", pkt_cnt, 16'd4);
        check("t1_err_cnt", err_cnt, 16'd0);

        // CC 0,1,3 on the checked PID, then on PID 0x0015; back-to-back bits
        do_reset();
        snap();
        send_pkt(PID_CHK, 4'd0, 0, 0, -1);
        send_pkt(PID_CHK, 4'd1, 0, 0, -1);
        send_pkt(PID_CHK, 4'd3, 0, 0, -1);
        idle(5);
        check("t2_ccerrs",   16'(n_ccerr - b_ccerr), 16'd1);
        check("t2_cc_byte",  16'(last_cc_data),      16'h0013);
        check("t2_err_cnt",  err_cnt, 16'd1);
        send_pkt(13'h0015, 4'd0, 0, 0, -1);
        send_pkt(13'h0015, 4'd1, 0, 0, -1);
        send_pkt(13'h0015, 4'd3, 0, 0, -1);
        idle(5);
        check("t2_ccerrs_other_pid", 16'(n_ccerr - b_ccerr), 16'd1);
        check("t2_pkt_cnt", pkt_cnt, 16'd6);
        check("t2_err_cnt_final", err_cnt, 16'd1);

        // Bad sync byte 0xB8, then a good packet
        do_reset();
        snap();
        send_byte(8'hB8, 1'b1);
        idle(4);
        check("t3_no_strobe", 16'(n_valid - b_valid), 16'd0);
        check("t3_serr",      16'(n_serr - b_serr),   16'd1);
        send_pkt(PID_CHK, 4'd5, 2, 0, -1);
        idle(5);
        check("t3_strobes", 16'(n_valid - b_valid), 16'd188);
        check("t3_pkt_cnt", pkt_cnt, 16'd1);
        check("t3_err_cnt", err_cnt, 16'd1);

        // Second sync at byte 100 bit 3 truncates the first packet
        do_reset();
        snap();
        send_pkt(PID_CHK, 4'd7, 1, 0, 100 * 8 + 3);
        send_bit(1'b1, 1'b1);
        send_pkt(PID_CHK, 4'd8, 1, 1, -1);
        idle(5);
        check("t4_serr",    16'(n_serr - b_serr),   16'd1);
        check("t4_eops",    16'(n_eop - b_eop),     16'd1);
        check("t4_strobes", 16'(n_valid - b_valid), 16'd288);
        check("t4_pkt_cnt", pkt_cnt, 16'd1);
        check("t4_err_cnt", err_cnt, 16'd1);

        // Reset in the middle of byte 50; stale bits afterwards must be ignored
        do_reset();
        send_pkt(PID_CHK, 4'd2, 0, 0, 50 * 8 + 4);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_data",  16'(ts_if.ts_data),  16'h0000);
        check("t5_rst_valid", 16'(ts_if.ts_valid), 16'h0000);
        check("t5_rst_pkt",   pkt_cnt, 16'h0000);
        cyc();
        cyc();
        rst = 1'b0;
        snap();
        send_pkt(PID_CHK, 4'd2, 0, 8, 88);
        idle(4);
        check("t5_hunt_silent", 16'(n_valid - b_valid), 16'd0);
        send_pkt(PID_CHK, 4'd3, 0, 0, -1);
        idle(5);
        check("t5_strobes", 16'(n_valid - b_valid), 16'd188);
        check("t5_pkt_cnt", pkt_cnt, 16'd1);
        check("t5_err_cnt", err_cnt, 16'd0);

        // err_cnt saturation with both error pulses in one cycle
        chk_en = 1'b0;
        @(negedge clk);
        force dut.err_cnt  = 16'hFFFE;
        force dut.sync_err = 1'b1;
        force dut.cc_err   = 1'b1;
        @(negedge clk);
        release dut.err_cnt;
        @(negedge clk);
        release dut.sync_err;
        release dut.cc_err;
        check("t6_err_sat", err_cnt, 16'hFFFF);
        cyc();
        idle(4);
        check("t6_err_hold", err_cnt, 16'hFFFF);
        snap();
        send_byte(8'hB8, 1'b1);
        idle(4);
        check("t6_serr_again", 16'(n_serr - b_serr), 16'd1);
        check("t6_err_hold2", err_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
